// File: rtl/gamma_pwm_pkg.sv
// Shared types and widths for the gamma-corrected LED PWM scheduler and its timebase.
package gamma_pwm_pkg;

    localparam int CNT_W  = 8;
    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled 8-bit period counter, period boundary strobe and a registered
// period-start pulse that is high while the counter first shows zero.
module pwm_timebase
    import gamma_pwm_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_boundary,
    output logic             o_period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  r_prescale;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;
    logic             w_tick;
    logic             w_boundary;

    assign w_tick     = (r_prescale == PS_W'(PRESCALE - 1));
    assign w_boundary = w_tick && (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PS_W'(1);
        end
    end

    // The counter wraps naturally from 255 back to 0 on the boundary tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
        end
    end

    assign o_cnt          = r_cnt;
    assign o_boundary     = w_boundary;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/gamma_pwm_scheduler.sv
// Multi-channel LED PWM driver sharing one external gamma LUT; duties commit only at period boundaries.
// Optional macro GAMMA_PWM_FULL_ON_EN: a duty of 255 drives the output constantly high.
module gamma_pwm_scheduler
    import gamma_pwm_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [8*N_CH-1:0]   level_in,
    input  logic [N_CH-1:0]     level_we,
    output logic [7:0]          lut_value,
    input  logic [7:0]          lut_corrected,
    output logic [N_CH-1:0]     pwm_out,
    output logic                period_start,
    output logic                busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    duty_t            r_level  [N_CH];
    duty_t            r_shadow [N_CH];
    duty_t            r_active [N_CH];
    logic             r_dirty;
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;

    state_t           w_state_next;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_clear_dirty;
    logic             w_shadow_we;
    logic             w_commit;
    logic [CNT_W-1:0] w_cnt;
    logic             w_boundary;
    logic [N_CH-1:0]  w_pwm;

    pwm_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk           (clk),
        .resetn        (resetn),
        .o_cnt         (w_cnt),
        .o_boundary    (w_boundary),
        .o_period_start(period_start)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (level_we[i]) begin
                    r_level[i] <= level_in[8*i +: 8];
                end
            end
        end
    end

    // A new write must win over the clear issued when IDLE launches a scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dirty <= 1'b0;
        end else if (|level_we) begin
            r_dirty <= 1'b1;
        end else if (w_clear_dirty) begin
            r_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_clear_dirty = 1'b0;
        w_shadow_we   = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_dirty) begin
                    w_clear_dirty = 1'b1;
                    w_idx_next    = '0;
                    w_state_next  = SCAN;
                end
            end
            SCAN: begin
                w_shadow_we = 1'b1;
                if (r_idx == IDX_W'(N_CH - 1)) begin
                    w_idx_next   = '0;
                    w_state_next = READY;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            READY: begin
                if (w_boundary) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_idx_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_shadow_we) begin
            r_shadow[r_idx] <= lut_corrected;
        end
    end

    // All channels take their new duty on the same edge that wraps the counter to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < N_CH; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    always_comb begin
        w_pwm = '0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef GAMMA_PWM_FULL_ON_EN
            w_pwm[i] = (r_active[i] == {DUTY_W{1'b1}}) || (w_cnt < r_active[i]);
`else
            w_pwm[i] = (w_cnt < r_active[i]);
`endif
        end
    end

    assign pwm_out   = w_pwm;
    assign lut_value = r_level[r_idx];
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gamma_pwm_scheduler.sv
// Scoreboard bench for gamma_pwm_scheduler: per-period high counts are queued by the stimulus
// and compared by monitors at every period_start; a second instance exercises PRESCALE=4.
module tb_gamma_pwm_scheduler;

    localparam int N_CH = 3;

`ifdef GAMMA_PWM_FULL_ON_EN
    localparam int FULL_COUNT = 256;
`else
    localparam int FULL_COUNT = 255;
`endif

    typedef struct packed {
        int period;
        int h0;
        int h1;
        int h2;
    } expRec_t;

    logic                clk = 1'b0;
    logic                resetn;
    logic                resetnB;
    logic [8*N_CH-1:0]   levelIn;
    logic [8*N_CH-1:0]   levelInB;
    logic [N_CH-1:0]     levelWe;
    logic [N_CH-1:0]     levelWeB;
    logic [7:0]          lutValue;
    logic [7:0]          lutCorrected;
    logic [7:0]          lutValueB;
    logic [7:0]          lutCorrectedB;
    logic [N_CH-1:0]     pwmOut;
    logic [N_CH-1:0]     pwmOutB;
    logic                periodStart;
    logic                periodStartB;
    logic                busy;
    logic                busyB;

    int checks = 0;
    int passes = 0;

    expRec_t qA[$];
    expRec_t qB[$];

    int cycA;
    int cycB;
    int perA = 0;
    int perB = 0;
    int lastStartA = 0;
    int lastStartB = 0;
    int cntA[N_CH];
    int cntB[N_CH];

    always #5 clk = ~clk;

    // Gamma 1.8 with floor, hand-evaluated only at the levels this bench writes.
    function automatic logic [7:0] gammaLut(input logic [7:0] v);
        case (v)
            8'd11:   return 8'd0;
            8'd12:   return 8'd1;
            8'd128:  return 8'd73;
            8'd200:  return 8'd164;
            8'd255:  return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    assign lutCorrected  = gammaLut(lutValue);
    assign lutCorrectedB = gammaLut(lutValueB);

    gamma_pwm_scheduler #(.N_CH(N_CH), .PRESCALE(1)) dutA (
        .clk          (clk),
        .resetn       (resetn),
        .level_in     (levelIn),
        .level_we     (levelWe),
        .lut_value    (lutValue),
        .lut_corrected(lutCorrected),
        .pwm_out      (pwmOut),
        .period_start (periodStart),
        .busy         (busy)
    );

    gamma_pwm_scheduler #(.N_CH(N_CH), .PRESCALE(4)) dutB (
        .clk          (clk),
        .resetn       (resetnB),
        .level_in     (levelInB),
        .level_we     (levelWeB),
        .lut_value    (lutValueB),
        .lut_corrected(lutCorrectedB),
        .pwm_out      (pwmOutB),
        .period_start (periodStartB),
        .busy         (busyB)
    );

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pop the expectation for a finished period (if any) and compare its per-channel high counts.
    task automatic checkOutput(input int which, input int per, input int c0, input int c1, input int c2);
        expRec_t e;
        bit      have;
        string   tag;
        have = 1'b0;
        tag  = (which == 0) ? "A" : "B";
        if (which == 0) begin
            while (qA.size() > 0 && qA[0].period < per) begin
                e = qA.pop_front();
                checkVal($sformatf("%s.periodSeen", tag), per, e.period);
            end
            if (qA.size() > 0 && qA[0].period == per) begin
                e    = qA.pop_front();
                have = 1'b1;
            end
        end else begin
            while (qB.size() > 0 && qB[0].period < per) begin
                e = qB.pop_front();
                checkVal($sformatf("%s.periodSeen", tag), per, e.period);
            end
            if (qB.size() > 0 && qB[0].period == per) begin
                e    = qB.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            checkVal($sformatf("%s.p%0d.ch0", tag, per), c0, e.h0);
            checkVal($sformatf("%s.p%0d.ch1", tag, per), c1, e.h1);
            checkVal($sformatf("%s.p%0d.ch2", tag, per), c2, e.h2);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cycA <= 0;
        else         cycA <= cycA + 1;
    end

    always @(posedge clk or negedge resetnB) begin
        if (!resetnB) cycB <= 0;
        else          cycB <= cycB + 1;
    end

    // Monitor A: a period_start closes the previous period and must arrive every 256 cycles.
    always @(negedge clk) begin
        if (!resetn) begin
            perA       = 0;
            lastStartA = 0;
            for (int i = 0; i < N_CH; i++) cntA[i] = 0;
        end else begin
            if (periodStart) begin
                checkVal("A.periodSpacing", cycA - lastStartA, 256);
                if (perA > 0) checkOutput(0, perA, cntA[0], cntA[1], cntA[2]);
                perA++;
                lastStartA = cycA;
                for (int i = 0; i < N_CH; i++) cntA[i] = 0;
            end
            for (int i = 0; i < N_CH; i++) cntA[i] += int'(pwmOut[i]);
        end
    end

    // Monitor B: prescale of 4 stretches every period to 1024 clocks.
    always @(negedge clk) begin
        if (!resetnB) begin
            perB       = 0;
            lastStartB = 0;
            for (int i = 0; i < N_CH; i++) cntB[i] = 0;
        end else begin
            if (periodStartB) begin
                checkVal("B.periodSpacing", cycB - lastStartB, 1024);
                if (perB > 0) checkOutput(1, perB, cntB[0], cntB[1], cntB[2]);
                perB++;
                lastStartB = cycB;
                for (int i = 0; i < N_CH; i++) cntB[i] = 0;
            end
            for (int i = 0; i < N_CH; i++) cntB[i] += int'(pwmOutB[i]);
        end
    end

    task automatic waitToCyc(input int target);
        for (int i = 0; i < 5000 && cycA < target; i++) begin
            @(posedge clk);
            #1;
        end
        if (cycA != target) checkVal("waitToCyc", cycA, target);
    endtask

    // Drive a write to instance A; it is captured on the next rising edge.
    task automatic applyStimulus(input logic [N_CH-1:0] we, input logic [8*N_CH-1:0] lv);
        for (int i = 0; i < N_CH; i++) begin
            if (we[i]) levelIn[8*i +: 8] = lv[8*i +: 8];
        end
        levelWe = we;
        @(posedge clk);
        #1;
        levelWe = '0;
    endtask

    task automatic pushExp(input int which, input int per, input int h0, input int h1, input int h2);
        expRec_t e;
        e.period = per;
        e.h0     = h0;
        e.h1     = h1;
        e.h2     = h2;
        if (which == 0) qA.push_back(e);
        else            qB.push_back(e);
    endtask

    initial begin
        expRec_t e;
        resetn   = 1'b0;
        resetnB  = 1'b0;
        levelIn  = '0;
        levelInB = '0;
        levelWe  = '0;
        levelWeB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset.pwm", int'(pwmOut), 0);
        checkVal("reset.busy", int'(busy), 0);
        checkVal("reset.periodStart", int'(periodStart), 0);
        checkVal("reset.lutValue", int'(lutValue), 0);
        @(negedge clk);
        #2;
        resetn  = 1'b1;
        resetnB = 1'b1;

        // Instance B: level 128 -> duty 73, 73 ticks of 4 clocks high per period.
        waitToCyc(5);
        levelInB[7:0] = 8'd128;
        levelWeB      = 3'b001;
        @(posedge clk);
        #1;
        levelWeB = '0;
        pushExp(1, 1, 292, 0, 0);
        pushExp(1, 2, 292, 0, 0);

        // Single write: level 128 on ch0 commits at the first boundary (cycle 256).
        waitToCyc(10);
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd128});
        pushExp(0, 1, 73, 0, 0);
        waitToCyc(13);
        checkVal("busyDuringScan", int'(busy), 1);
        waitToCyc(20);
        checkVal("lutValueLevel0", int'(lutValue), 128);
        waitToCyc(260);
        checkVal("busyAfterCommit", int'(busy), 0);

        // Mid-period write at cnt 100: period 1 keeps 73, period 2 shows 164.
        waitToCyc(356);
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd200});
        pushExp(0, 2, 164, 0, 0);

        // Simultaneous writes hitting LUT edges: 255 on ch0, 11 on ch1, 12 on ch2.
        waitToCyc(522);
        applyStimulus(3'b111, {8'd12, 8'd11, 8'd255});
        pushExp(0, 3, FULL_COUNT, 0, 1);

        // Rewrite ch0 while idx==1: stale 73 commits first, the rescan brings 164.
        waitToCyc(778);
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd128});
        waitToCyc(781);
        checkVal("busyMidScan", int'(busy), 1);
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd200});
        pushExp(0, 4, 73, 0, 1);
        pushExp(0, 5, 164, 0, 1);

        // Second write lands on the IDLE->SCAN edge, so a rescan must follow the commit.
        waitToCyc(1290);
        applyStimulus(3'b100, {8'd128, 8'd0, 8'd0});
        applyStimulus(3'b010, {8'd0, 8'd200, 8'd0});
        pushExp(0, 6, 164, 164, 73);
        waitToCyc(1540);
        checkVal("busyRescan", int'(busy), 1);

        // Reset mid-period at cnt 50.
        waitToCyc(1842);
        checkVal("pwmBeforeReset", int'(pwmOut), 7);
        resetn = 1'b0;
        #1;
        checkVal("midReset.pwm", int'(pwmOut), 0);
        checkVal("midReset.busy", int'(busy), 0);
        checkVal("midReset.periodStart", int'(periodStart), 0);
        checkVal("midReset.lutValue", int'(lutValue), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        pushExp(0, 1, 0, 0, 0);
        waitToCyc(5);
        checkVal("postReset.lutValue", int'(lutValue), 0);
        checkVal("postReset.busy", int'(busy), 0);

        for (int i = 0; i < 6000 && (qA.size() > 0 || qB.size() > 0); i++) begin
            @(posedge clk);
        end
        while (qA.size() > 0) begin
            e = qA.pop_front();
            checkVal("A.periodNeverSeen", -1, e.period);
        end
        while (qB.size() > 0) begin
            e = qB.pop_front();
            checkVal("B.periodNeverSeen", -1, e.period);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
